if_fetch_stage: RTL and testbench

//  Instruction-fetch stage with IF/ID pipeline register. Sits directly upstream of the

---
 rtl/if_fetch_stage_pkg.sv | 35 +++
 rtl/if_fetch_stage_bus_if.sv | 118 +++++++++++
 rtl/if_fetch_stage.sv | 111 +++++++++++
 tb/tb_if_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, ISA constants,
// memory-map region select and the bus-interface state encoding.
package if_fetch_stage_pkg;

    localparam int unsigned WordAddrW  = 30;
    localparam int unsigned WordDataW  = 32;
    localparam int unsigned RegionIdxW = 3;

    // Instruction injected into IF/ID on reset and flush
    localparam logic [WordDataW-1:0]  IsaNop    = 32'h0000_0000;

    // Value of the top address bits that maps onto the scratch-pad memory
    localparam logic [RegionIdxW-1:0] SpmRegion = 3'd1;

    // Read/write direction encoding shared by SPM and bus
    localparam logic Read  = 1'b1;
    localparam logic Write = 1'b0;

    // Active-low strobe levels
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StAccess = 2'd2,
        StStall  = 2'd3
    } bus_if_state_e;

    // Memory-map region of a word address
    function automatic logic [RegionIdxW-1:0] region_idx(input logic [WordAddrW-1:0] addr);
        return addr[WordAddrW-1 -: RegionIdxW];
    endfunction

endpackage

// File: rtl/if_fetch_stage_bus_if.sv
// Fetch memory interface: selects SPM (zero-wait, combinational read) or the
// system bus (request/grant/strobe/ready handshake), and returns the fetched
// instruction plus a busy indication while a bus fetch is outstanding.
module if_fetch_stage_bus_if
    import if_fetch_stage_pkg::*;
#(
    parameter logic [RegionIdxW-1:0] SpmIdx  = SpmRegion,
    parameter logic [WordDataW-1:0]  NopInsn = IsaNop
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [WordAddrW-1:0] addr,
    output logic [WordDataW-1:0] insn,
    output logic                 busy,
    input  logic [WordDataW-1:0] spm_rd_data,
    output logic [WordAddrW-1:0] spm_addr,
    output logic                 spm_as_,
    output logic                 spm_rw,
    input  logic [WordDataW-1:0] bus_rd_data,
    input  logic                 bus_rdy_,
    input  logic                 bus_grnt_,
    output logic                 bus_req_,
    output logic [WordAddrW-1:0] bus_addr,
    output logic                 bus_as_,
    output logic                 bus_rw
);

    bus_if_state_e        state_q, state_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_as_q, bus_as_d;
    logic [WordAddrW-1:0] bus_addr_q, bus_addr_d;
    logic [WordDataW-1:0] rd_buf_q, rd_buf_d;
    logic                 spm_sel;

    assign spm_sel  = (region_idx(addr) == SpmIdx);

    assign spm_addr = addr;
    assign spm_rw   = Read;
    assign bus_rw   = Read;
    assign bus_req_ = bus_req_q;
    assign bus_as_  = bus_as_q;
    assign bus_addr = bus_addr_q;

    // Next-state, bus-register next values and combinational read mux / busy
    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_as_d   = bus_as_q;
        bus_addr_d = bus_addr_q;
        rd_buf_d   = rd_buf_q;
        insn       = NopInsn;
        busy       = 1'b0;
        spm_as_    = Disable_;

        case (state_q)
            StIdle: begin
                if (spm_sel) begin
                    spm_as_ = Enable_;
                    insn    = spm_rd_data;
                end else begin
                    busy      = 1'b1;
                    bus_req_d = Enable_;
                    state_d   = StReq;
                end
            end
            StReq: begin
                busy = 1'b1;
                if (bus_grnt_ == Enable_) begin
                    // Address strobe is a single-cycle pulse in the first ACCESS cycle
                    bus_as_d   = Enable_;
                    bus_addr_d = addr;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                bus_as_d = Disable_;
                if (bus_rdy_ == Enable_) begin
                    // Data goes straight through this cycle and is also kept for STALL
                    insn       = bus_rd_data;
                    rd_buf_d   = bus_rd_data;
                    bus_req_d  = Disable_;
                    bus_addr_d = '0;
                    state_d    = stall ? StStall : StIdle;
                end else begin
                    busy = 1'b1;
                end
            end
            StStall: begin
                insn = rd_buf_q;
                if (!stall) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state and bus output registers; reset abandons any outstanding access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bus_req_q  <= Disable_;
            bus_as_q   <= Disable_;
            bus_addr_q <= '0;
            rd_buf_q   <= '0;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_as_q   <= bus_as_d;
            bus_addr_q <= bus_addr_d;
            rd_buf_q   <= rd_buf_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register, and
// fetches through the SPM/bus interface. Stall, flush and branch redirects are
// applied in that priority order at each register update.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [WordAddrW-1:0]  ResetVector = '0,
    parameter logic [RegionIdxW-1:0] SpmIdx      = SpmRegion,
    parameter logic [WordDataW-1:0]  NopInsn     = IsaNop
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [WordAddrW-1:0] new_pc,
    input  logic                 br_taken,
    input  logic [WordAddrW-1:0] br_addr,
    output logic                 busy,
    input  logic [WordDataW-1:0] spm_rd_data,
    output logic [WordAddrW-1:0] spm_addr,
    output logic                 spm_as_,
    output logic                 spm_rw,
    input  logic [WordDataW-1:0] bus_rd_data,
    input  logic                 bus_rdy_,
    input  logic                 bus_grnt_,
    output logic                 bus_req_,
    output logic [WordAddrW-1:0] bus_addr,
    output logic                 bus_as_,
    output logic                 bus_rw,
    output logic [WordAddrW-1:0] if_pc,
    output logic [WordDataW-1:0] if_insn,
    output logic                 if_en
);

    logic [WordAddrW-1:0] pc_q, pc_d;
    logic [WordAddrW-1:0] if_pc_q, if_pc_d;
    logic [WordDataW-1:0] if_insn_q, if_insn_d;
    logic                 if_en_q, if_en_d;
    logic [WordDataW-1:0] insn;

    assign if_pc   = if_pc_q;
    assign if_insn = if_insn_q;
    assign if_en   = if_en_q;

    if_fetch_stage_bus_if #(
        .SpmIdx  (SpmIdx),
        .NopInsn (NopInsn)
    ) u_fetch_bus_if (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .addr        (pc_q),
        .insn        (insn),
        .busy        (busy),
        .spm_rd_data (spm_rd_data),
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_),
        .bus_grnt_   (bus_grnt_),
        .bus_req_    (bus_req_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw)
    );

    // PC and IF/ID next values: stall > flush > branch > sequential
    always_comb begin
        pc_d      = pc_q;
        if_pc_d   = if_pc_q;
        if_insn_d = if_insn_q;
        if_en_d   = if_en_q;

        if (stall) begin
            // hold everything
        end else if (flush) begin
            pc_d      = new_pc;
            if_pc_d   = '0;
            if_insn_d = NopInsn;
            if_en_d   = 1'b0;
        end else if (br_taken) begin
            pc_d      = br_addr;
            if_pc_d   = pc_q;
            if_insn_d = insn;
            if_en_d   = 1'b1;
        end else begin
            // Wraps modulo 2^WordAddrW
            pc_d      = pc_q + WordAddrW'(1);
            if_pc_d   = pc_q;
            if_insn_d = insn;
            if_en_d   = 1'b1;
        end
    end

    // PC and IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= ResetVector;
            if_pc_q   <= '0;
            if_insn_q <= NopInsn;
            if_en_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            if_pc_q   <= if_pc_d;
            if_insn_q <= if_insn_d;
            if_en_q   <= if_en_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage. A transaction-level model tracks PC and IF/ID from
// the update-priority rules; SPM and bus fetches are driven as directed and
// randomized transactions with cycle-level protocol checks.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam logic [29:0] RV = 30'h0;

    logic        clk = 1'b0;
    logic        reset, stall, mem_stall, flush, br_taken;
    logic [29:0] new_pc, br_addr;
    logic        busy;
    logic [31:0] spm_rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_, spm_rw;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_, bus_grnt_, bus_req_, bus_as_, bus_rw;
    logic [29:0] bus_addr;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;

    logic [31:0] spm_mem [16];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [29:0] pc_m, if_pc_m;
    logic [31:0] if_insn_m;
    logic        if_en_m;

    always #5 clk = ~clk;

    // Control unit stand-in: busy feeds the stall
    assign stall       = busy | mem_stall;
    assign spm_rd_data = spm_mem[spm_addr[3:0]];

    if_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .busy        (busy),
        .spm_rd_data (spm_rd_data),
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_),
        .bus_grnt_   (bus_grnt_),
        .bus_req_    (bus_req_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .if_en       (if_en)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic in_spm(input logic [29:0] a);
        return a[29:27] == SpmRegion;
    endfunction

    function automatic logic [29:0] rand_target();
        if ($urandom_range(0, 3) == 0) return 30'($urandom);
        return {SpmRegion, 27'($urandom)};
    endfunction

    // Apply the register-update rules for the coming edge
    task automatic model_edge(input logic st, input logic [31:0] insn_e);
        if (reset) begin
            pc_m = RV; if_pc_m = '0; if_insn_m = IsaNop; if_en_m = 1'b0;
        end else if (st) begin
            // hold
        end else if (flush) begin
            pc_m = new_pc; if_pc_m = '0; if_insn_m = IsaNop; if_en_m = 1'b0;
        end else if (br_taken) begin
            if_pc_m = pc_m; if_insn_m = insn_e; if_en_m = 1'b1; pc_m = br_addr;
        end else begin
            if_pc_m = pc_m; if_insn_m = insn_e; if_en_m = 1'b1; pc_m = pc_m + 30'd1;
        end
    endtask

    task automatic clk_edge(input logic st, input logic [31:0] insn_e);
        model_edge(st, insn_e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pc"}, 32'(spm_addr), 32'(pc_m));
        chk({tag, ".if_pc"}, 32'(if_pc), 32'(if_pc_m));
        chk({tag, ".if_insn"}, if_insn, if_insn_m);
        chk({tag, ".if_en"}, 32'(if_en), 32'(if_en_m));
    endtask

    // One SPM fetch cycle (pc in SPM region, interface idle)
    task automatic spm_cycle(input logic ms, input logic fl, input logic bt,
                             input logic [29:0] npc, input logic [29:0] baddr);
        mem_stall = ms; flush = fl; br_taken = bt; new_pc = npc; br_addr = baddr;
        #1;
        chk("spm.busy", 32'(busy), 32'd0);
        chk("spm.spm_as_", 32'(spm_as_), 32'd0);
        chk("spm.bus_req_", 32'(bus_req_), 32'd1);
        clk_edge(ms, spm_mem[pc_m[3:0]]);
        mem_stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        check_regs("spm");
    endtask

    // One bus fetch: gw grant-wait cycles, rw ready-wait cycles, mem-side stall
    // held for 'hold' cycles starting at the ready cycle; fl/bt applied at ready
    task automatic bus_fetch(input int gw, input int rw, input int hold,
                             input logic fl, input logic bt, input logic [29:0] tgt);
        logic [31:0] d;
        logic [29:0] a;
        d = $urandom;
        a = pc_m;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; mem_stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        #1;
        chk("bus.idle_busy", 32'(busy), 32'd1);
        chk("bus.idle_spm_as_", 32'(spm_as_), 32'd1);
        chk("bus.idle_req_", 32'(bus_req_), 32'd1);
        clk_edge(1'b1, 32'd0);
        chk("bus.req_low", 32'(bus_req_), 32'd0);
        for (int i = 0; i < gw; i++) begin
            // Redirects while busy must have no effect
            br_taken = 1'($urandom_range(0, 1)); br_addr = 30'($urandom);
            #1;
            chk("bus.gwait_busy", 32'(busy), 32'd1);
            chk("bus.gwait_as_", 32'(bus_as_), 32'd1);
            clk_edge(1'b1, 32'd0);
        end
        br_taken = 1'b0;
        bus_grnt_ = 1'b0;
        #1;
        chk("bus.grant_busy", 32'(busy), 32'd1);
        chk("bus.grant_as_", 32'(bus_as_), 32'd1);
        clk_edge(1'b1, 32'd0);
        bus_grnt_ = 1'b1;
        chk("bus.as_pulse", 32'(bus_as_), 32'd0);
        chk("bus.addr", 32'(bus_addr), 32'(a));
        for (int i = 0; i < rw; i++) begin
            #1;
            chk("bus.rwait_busy", 32'(busy), 32'd1);
            clk_edge(1'b1, 32'd0);
            chk("bus.as_single", 32'(bus_as_), 32'd1);
            chk("bus.rwait_req_", 32'(bus_req_), 32'd0);
        end
        bus_rdy_ = 1'b0; bus_rd_data = d;
        mem_stall = (hold > 0); flush = fl; br_taken = bt; new_pc = tgt; br_addr = tgt;
        #1;
        chk("bus.rdy_busy", 32'(busy), 32'd0);
        chk("bus.rdy_req_", 32'(bus_req_), 32'd0);
        clk_edge(mem_stall, d);
        bus_rdy_ = 1'b1; bus_rd_data = $urandom; flush = 1'b0; br_taken = 1'b0;
        chk("bus.done_req_", 32'(bus_req_), 32'd1);
        chk("bus.done_as_", 32'(bus_as_), 32'd1);
        check_regs("bus.done");
        if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                #1;
                chk("bus.stall_busy", 32'(busy), 32'd0);
                clk_edge(1'b1, d);
                check_regs("bus.stall");
            end
            mem_stall = 1'b0;
            #1;
            chk("bus.release_busy", 32'(busy), 32'd0);
            clk_edge(1'b0, d);
            check_regs("bus.release");
        end
    endtask

    task automatic fetch_one();
        if (in_spm(pc_m)) begin
            spm_cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0), rand_target(), rand_target());
        end else begin
            bus_fetch($urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                      rand_target());
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) spm_mem[i] = $urandom;
        reset = 1'b1; mem_stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        new_pc = '0; br_addr = '0; bus_rd_data = '0; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        pc_m = '1; if_pc_m = '1; if_insn_m = '1; if_en_m = 1'b1;

        // Reset for two cycles
        @(negedge clk);
        clk_edge(1'b0, 32'd0);
        clk_edge(1'b0, 32'd0);
        reset = 1'b0;
        check_regs("reset");
        chk("reset.bus_req_", 32'(bus_req_), 32'd1);
        chk("reset.bus_as_", 32'(bus_as_), 32'd1);
        chk("reset.bus_addr", 32'(bus_addr), 32'd0);
        chk("reset.spm_rw", 32'(spm_rw), 32'(Read));
        chk("reset.bus_rw", 32'(bus_rw), 32'(Read));

        // Reset vector lies in the bus region: first fetch, then branch to 0x10
        bus_fetch(0, 0, 0, 1'b0, 1'b1, 30'h0000_0010);
        // Fetch at 0x10 with grant after 2 and ready after 3; flush into SPM
        bus_fetch(2, 3, 0, 1'b1, 1'b0, 30'h0800_0000);

        // Three back-to-back SPM fetches
        for (int i = 0; i < 3; i++) spm_cycle(1'b0, 1'b0, 1'b0, '0, '0);

        // Flush and branch together: flush wins
        spm_cycle(1'b0, 1'b1, 1'b1, 30'h0000_0100, 30'h0800_0040);

        // Mem-side stall held four cycles across ready
        bus_fetch(1, 1, 4, 1'b0, 1'b0, '0);

        // PC wrap at the top of the address space
        bus_fetch(0, 1, 0, 1'b1, 1'b0, 30'h3FFF_FFFF);
        bus_fetch(1, 0, 0, 1'b0, 1'b0, '0);

        // Reset while an access is in progress
        #1;
        chk("rst_acc.idle_busy", 32'(busy), 32'd1);
        clk_edge(1'b1, 32'd0);
        bus_grnt_ = 1'b0;
        #1;
        clk_edge(1'b1, 32'd0);
        bus_grnt_ = 1'b1;
        chk("rst_acc.as_", 32'(bus_as_), 32'd0);
        reset = 1'b1;
        #1;
        clk_edge(1'b1, 32'd0);
        reset = 1'b0;
        chk("rst_acc.bus_req_", 32'(bus_req_), 32'd1);
        chk("rst_acc.bus_as_", 32'(bus_as_), 32'd1);
        chk("rst_acc.bus_addr", 32'(bus_addr), 32'd0);
        check_regs("rst_acc");
        // Back in IDLE: ready from the fabric must not end a fetch here
        bus_rdy_ = 1'b0;
        #1;
        chk("rst_acc.state_idle", 32'(busy), 32'd1);
        bus_rdy_ = 1'b1;
        #1;

        // Randomized mix of SPM and bus fetches with redirects and stalls
        for (int n = 0; n < 150; n++) fetch_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
